// File: rtl/capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : capture_pkg
//  Description : Shared types and constants for the ADC capture sequencer:
//                FSM state encoding, register word offsets, CTRL/STATUS bit
//                positions and the STATUS word packing helper.
//  Revision    : 1.0  initial release
// ============================================================================
package capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    // Register word index (byte address bits [3:2])
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_LEN    = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_START  = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_ABORT  = 3;

    // STATUS bit positions
    localparam int STS_BUSY  = 0;
    localparam int STS_DONE  = 1;
    localparam int STS_OVF   = 2;
    localparam int STS_ARMED = 3;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Pack the STATUS read word from its individual flags
    function automatic logic [31:0] status_word(input logic busy, input logic done,
                                                input logic ovf,  input logic armed);
        logic [31:0] w;
        w            = '0;
        w[STS_BUSY]  = busy;
        w[STS_DONE]  = done;
        w[STS_OVF]   = ovf;
        w[STS_ARMED] = armed;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/capture_axil_if.sv
`default_nettype none
// ============================================================================
//  Module      : capture_axil_if
//  Description : AXI4-Lite slave bus bundle used by the capture sequencer.
//                master modport = bus initiator (PS), slave modport = block.
//  Revision    : 1.0  initial release
// ============================================================================
interface capture_axil_if #(
    parameter int ADDR_W = 4
) ();
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/capture_axil_regs.sv
`default_nettype none
// ============================================================================
//  Module      : capture_axil_regs
//  Description : AXI4-Lite handshake and register file for capture_ctrl.
//                CTRL (EN, IRQ_EN rw; START, ABORT self-clearing pulses),
//                STATUS (BUSY/ARMED live, DONE/OVF sticky w1c), LEN rw,
//                COUNT ro. Write strobes are ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module capture_axil_regs
    import capture_pkg::*;
#(
    parameter int LEN_W  = 24,
    parameter int ADDR_W = 4
) (
    input  wire logic             clk,
    input  wire logic             resetn,
    capture_axil_if.slave         axil,
    output logic                  en_o,
    output logic                  irq_en_o,
    output logic                  start_o,
    output logic                  abort_o,
    output logic [LEN_W-1:0]      len_o,
    output logic                  irq_o,
    input  wire logic             busy_i,
    input  wire logic             armed_i,
    input  wire logic             done_set_i,
    input  wire logic             ovf_set_i,
    input  wire logic [LEN_W-1:0] count_i
);

    logic              awready_q;
    logic              bvalid_q;
    logic              arready_q;
    logic              rvalid_q;
    logic [31:0]       rdata_q;
    logic              en_q;
    logic              irq_en_q;
    logic              start_q;
    logic              abort_q;
    logic              done_q;
    logic              ovf_q;
    logic [LEN_W-1:0]  len_q;

    logic [ADDR_W-3:0] w_wr_idx;
    logic [ADDR_W-3:0] w_rd_idx;
    logic              w_wr_hs;
    logic              w_rd_hs;
    logic              w_w1c;
    logic [31:0]       w_rd_word;
    logic              w_unused;

    assign w_wr_idx = axil.awaddr[ADDR_W-1:2];
    assign w_rd_idx = axil.araddr[ADDR_W-1:2];
    // awready stays high for exactly the handshake cycle, so it qualifies the transfer
    assign w_wr_hs  = awready_q & axil.awvalid & axil.wvalid;
    assign w_rd_hs  = arready_q & axil.arvalid;
    assign w_w1c    = w_wr_hs & (w_wr_idx == (ADDR_W-2)'(REG_STATUS));

    assign w_unused = ^{axil.wstrb, axil.wdata, axil.awaddr[1:0], axil.araddr[1:0]};

    // Read data mux; any index outside the four words returns zero
    always_comb begin
        w_rd_word = '0;
        if (w_rd_idx == (ADDR_W-2)'(REG_CTRL)) begin
            w_rd_word[CTRL_EN]     = en_q;
            w_rd_word[CTRL_IRQ_EN] = irq_en_q;
        end else if (w_rd_idx == (ADDR_W-2)'(REG_STATUS)) begin
            w_rd_word = status_word(busy_i, done_q, ovf_q, armed_i);
        end else if (w_rd_idx == (ADDR_W-2)'(REG_LEN)) begin
            w_rd_word = 32'(len_q);
        end else if (w_rd_idx == (ADDR_W-2)'(REG_COUNT)) begin
            w_rd_word = 32'(count_i);
        end
    end

    // AXI-Lite channel handshakes and register updates
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            len_q     <= '0;
        end else begin
            start_q <= 1'b0;
            abort_q <= 1'b0;

            if (awready_q) begin
                awready_q <= 1'b0;
            end else if (axil.awvalid && axil.wvalid && !bvalid_q) begin
                awready_q <= 1'b1;
            end

            if (w_wr_hs) begin
                bvalid_q <= 1'b1;
            end else if (bvalid_q && axil.bready) begin
                bvalid_q <= 1'b0;
            end

            if (w_wr_hs && (w_wr_idx == (ADDR_W-2)'(REG_CTRL))) begin
                en_q     <= axil.wdata[CTRL_EN];
                irq_en_q <= axil.wdata[CTRL_IRQ_EN];
                abort_q  <= axil.wdata[CTRL_ABORT];
                // ABORT in the same write suppresses START
                start_q  <= axil.wdata[CTRL_START] & ~axil.wdata[CTRL_ABORT];
            end
            if (w_wr_hs && (w_wr_idx == (ADDR_W-2)'(REG_LEN))) begin
                len_q <= axil.wdata[LEN_W-1:0];
            end

            // Sticky flags: a new set event beats a simultaneous clear
            done_q <= done_set_i | (done_q & ~(w_w1c & axil.wdata[STS_DONE]));
            ovf_q  <= ovf_set_i  | (ovf_q  & ~(w_w1c & axil.wdata[STS_OVF]));

            if (arready_q) begin
                arready_q <= 1'b0;
            end else if (axil.arvalid && !rvalid_q) begin
                arready_q <= 1'b1;
            end

            if (w_rd_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= w_rd_word;
            end else if (rvalid_q && axil.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign axil.awready = awready_q;
    assign axil.wready  = awready_q;
    assign axil.bvalid  = bvalid_q;
    assign axil.bresp   = AXI_RESP_OKAY;
    assign axil.arready = arready_q;
    assign axil.rvalid  = rvalid_q;
    assign axil.rdata   = rdata_q;
    assign axil.rresp   = AXI_RESP_OKAY;

    assign en_o     = en_q;
    assign irq_en_o = irq_en_q;
    assign start_o  = start_q;
    assign abort_o  = abort_q;
    assign len_o    = len_q;
    assign irq_o    = done_q & irq_en_q;

endmodule
`default_nettype wire

// File: rtl/capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : capture_ctrl
//  Description : AXI4-Lite controlled ADC capture sequencer. On START streams
//                LEN samples to an AXI4-Stream master with tlast on the final
//                beat, then flags DONE / IRQ. Samples arriving while the
//                output beat is stalled are dropped and flagged as OVF.
//                Optional build macro CAPTURE_TRIG_EN adds a trig input and
//                an ARMED state that waits for a trig rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 24,
    parameter int ADDR_W = 4
) (
    input  wire logic              clk,
    input  wire logic              resetn,
    capture_axil_if.slave          s_axi,
    input  wire logic              smp_valid,
    input  wire logic [DATA_W-1:0] smp_data,
    output logic                   m_tvalid,
    output logic [DATA_W-1:0]      m_tdata,
    output logic                   m_tlast,
    input  wire logic              m_tready,
`ifdef CAPTURE_TRIG_EN
    input  wire logic              trig,
`endif
    output logic                   irq
);

    logic              w_en;
    logic              w_irq_en;
    logic              w_start;
    logic              w_abort;
    logic [LEN_W-1:0]  w_len;

    cap_state_t        state_q;
    logic [LEN_W-1:0]  count_q;
    logic [LEN_W-1:0]  count_d;
    logic [LEN_W-1:0]  len_q;
    logic              tvalid_q;
    logic              tlast_q;
    logic [DATA_W-1:0] tdata_q;
`ifdef CAPTURE_TRIG_EN
    logic              trig_q;
`endif

    logic w_stop;
    logic w_accept;
    logic w_last_acc;
    logic w_load;
    logic w_ovf_set;
    logic w_done_set;
    logic w_busy;
    logic w_armed;
    logic w_unused;

    capture_axil_regs #(
        .LEN_W  (LEN_W),
        .ADDR_W (ADDR_W)
    ) u_regs (
        .clk        (clk),
        .resetn     (resetn),
        .axil       (s_axi),
        .en_o       (w_en),
        .irq_en_o   (w_irq_en),
        .start_o    (w_start),
        .abort_o    (w_abort),
        .len_o      (w_len),
        .irq_o      (irq),
        .busy_i     (w_busy),
        .armed_i    (w_armed),
        .done_set_i (w_done_set),
        .ovf_set_i  (w_ovf_set),
        .count_i    (count_q)
    );

    assign w_unused   = w_irq_en;
    assign w_stop     = w_abort | ~w_en;
    assign w_accept   = tvalid_q & m_tready;
    assign w_last_acc = w_accept & tlast_q;
    // Output register can take a new sample when empty or draining this cycle
    assign w_load     = smp_valid & (~tvalid_q | m_tready) & ~w_last_acc;
    assign count_d    = count_q + LEN_W'(w_accept);
    assign w_ovf_set  = (state_q == ST_CAPTURE) & ~w_stop & smp_valid & tvalid_q & ~m_tready;
    assign w_done_set = (state_q == ST_DONE);
    assign w_busy     = (state_q == ST_CAPTURE) | (state_q == ST_ARMED);
    assign w_armed    = (state_q == ST_ARMED);

    // Capture FSM with registered stream outputs and beat counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            len_q    <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
`ifdef CAPTURE_TRIG_EN
            trig_q   <= 1'b0;
`endif
        end else begin
`ifdef CAPTURE_TRIG_EN
            trig_q <= trig;
`endif
            case (state_q)
                ST_IDLE: begin
                    tvalid_q <= 1'b0;
                    tlast_q  <= 1'b0;
                    if (w_start && w_en && (w_len != '0)) begin
                        count_q <= '0;
                        len_q   <= w_len;
`ifdef CAPTURE_TRIG_EN
                        state_q <= ST_ARMED;
`else
                        state_q <= ST_CAPTURE;
`endif
                    end
                end
                ST_ARMED: begin
                    if (w_stop) begin
                        state_q <= ST_IDLE;
`ifdef CAPTURE_TRIG_EN
                    end else if (trig && !trig_q) begin
                        state_q <= ST_CAPTURE;
`endif
                    end
                end
                ST_CAPTURE: begin
                    if (w_stop) begin
                        state_q  <= ST_IDLE;
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                    end else begin
                        if (w_accept) begin
                            count_q <= count_d;
                        end
                        if (w_last_acc) begin
                            state_q  <= ST_DONE;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                        end else if (w_load) begin
                            tvalid_q <= 1'b1;
                            tdata_q  <= smp_data;
                            // count_d is the index this new beat will occupy
                            tlast_q  <= (count_d == (len_q - LEN_W'(1)));
                        end else if (w_accept) begin
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_tvalid = tvalid_q;
    assign m_tdata  = tdata_q;
    assign m_tlast  = tlast_q;

endmodule
`default_nettype wire
